// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package insn_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  FC_NONE     = 2'b00;
   localparam logic [1:0]  FC_MISALIGN = 2'b01;
   localparam logic [1:0]  FC_TIMEOUT  = 2'b10;

   localparam logic [31:0] INSN_NOP    = 32'h0000_0013;

   // Targets are half-word aligned by clearing bit 0; bit 1 is left for the caller to trap on.
   function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                                input logic        sel,
                                                input logic [31:0] target);
      return sel ? {target[31:1], 1'b0} : pc + 32'd4;
   endfunction

endpackage

// File: rtl/insn_fetch_wait_timer.sv
// Counts consecutive FETCH cycles without mem_ready; expired marks the timeout cycle.
module fetch_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == CW'(WAIT_MAX));

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch sequencer: requests a word at pc, holds it for decode/execute,
// then commits the next pc. Timeout and misaligned-target faults are sticky until reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; waits for run
// FETCH    | mem_req high at pc until mem_ready or wait timeout
// ISSUE    | insn/pc valid for decode; waits for exec_done to update pc
// FAULT    | fault latched with its code; leaves only through reset
module insn_fetch
   import insn_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] insn,
   output logic [31:0] pc,
   output logic        insn_valid,
   input  logic        exec_done,
   input  logic        pc_next_sel,
   input  logic [31:0] pc_target,
   output logic        fault,
   output logic [1:0]  fault_code
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_insn;
   logic         r_mem_req;
   logic         r_insn_valid;
   logic         r_fault;
   logic [1:0]   r_fault_code;

   logic         w_in_fetch;
   logic         w_timer_clr;
   logic         w_timer_en;
   logic         w_expired;
   logic [31:0]  w_next_pc;

   assign w_in_fetch  = (r_state == ST_FETCH);
   assign w_timer_clr = !w_in_fetch || mem_ready;
   assign w_timer_en  = w_in_fetch && !mem_ready;
   assign w_next_pc   = calc_next_pc(r_pc, pc_next_sel, pc_target);

   fetch_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_timer_clr),
      .i_en      (w_timer_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_insn       <= INSN_NOP;
         r_mem_req    <= 1'b0;
         r_insn_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= FC_NONE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (run) begin
                  r_state   <= ST_FETCH;
                  r_mem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               // A transfer on the last allowed cycle wins over the timeout.
               if (mem_ready) begin
                  r_insn       <= mem_rdata;
                  r_state      <= ST_ISSUE;
                  r_mem_req    <= 1'b0;
                  r_insn_valid <= 1'b1;
               end else if (w_expired) begin
                  r_state      <= ST_FAULT;
                  r_mem_req    <= 1'b0;
                  r_fault      <= 1'b1;
                  r_fault_code <= FC_TIMEOUT;
               end
            end
            ST_ISSUE: begin
               if (exec_done) begin
                  r_insn_valid <= 1'b0;
                  if (w_next_pc[1]) begin
                     r_state      <= ST_FAULT;
                     r_fault      <= 1'b1;
                     r_fault_code <= FC_MISALIGN;
                  end else begin
                     r_pc <= w_next_pc;
                     if (run) begin
                        r_state   <= ST_FETCH;
                        r_mem_req <= 1'b1;
                     end else begin
                        r_state   <= ST_IDLE;
                     end
                  end
               end
            end
            ST_FAULT: begin
               r_mem_req    <= 1'b0;
               r_insn_valid <= 1'b0;
               r_fault      <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_addr   = r_pc;
   assign pc         = r_pc;
   assign insn       = r_insn;
   assign insn_valid = r_insn_valid;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: a table of fetch/commit records plus hand sequences
// for timeout, priority, async reset in ISSUE and run-gated restart.
module tb_insn_fetch;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] insn;
   logic [31:0] pc;
   logic        insn_valid;
   logic        exec_done;
   logic        pc_next_sel;
   logic [31:0] pc_target;
   logic        fault;
   logic [1:0]  fault_code;

   int total = 0;
   int bad   = 0;

   insn_fetch #(
      .RESET_PC (32'h0000_0000),
      .WAIT_MAX (15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .insn        (insn),
      .pc          (pc),
      .insn_valid  (insn_valid),
      .exec_done   (exec_done),
      .pc_next_sel (pc_next_sel),
      .pc_target   (pc_target),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        sel;
      logic [31:0] tgt;
      logic [31:0] exp_next;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mem_req"},    {31'd0, mem_req},    32'd0);
      chk({tag, "_insn_valid"}, {31'd0, insn_valid}, 32'd0);
      chk({tag, "_fault"},      {31'd0, fault},      32'd0);
      chk({tag, "_fault_code"}, {30'd0, fault_code}, 32'd0);
      chk({tag, "_pc"},         pc,                  32'h0000_0000);
      chk({tag, "_insn"},       insn,                32'h0000_0013);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h0000_0000, 32'hA000_0001, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'hA000_0002, 1'b1, 32'h0000_0101, 32'h0000_0100, 1'b0};
      vecs[2] = '{32'h0000_0100, 32'hA000_0003, 1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1};
      vecs[3] = '{32'h0000_0000, 32'hA000_0004, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
      vecs[4] = '{32'hFFFF_FFFC, 32'hA000_0005, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'hA000_0006, 1'b1, 32'h0000_0008, 32'h0000_0008, 1'b0};
      vecs[6] = '{32'h0000_0008, 32'hA000_0007, 1'b0, 32'h0,         32'h0000_000C, 1'b0};
      vecs[7] = '{32'h0000_000C, 32'hA000_0008, 1'b1, 32'h0000_0013, 32'h0000_000C, 1'b1};

      rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
      exec_done = 1'b0; pc_next_sel = 1'b0; pc_target = 32'h0;
      #12;
      chk_reset_vals("rst");

      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("idle_no_run_req", {31'd0, mem_req}, 32'd0);
      run = 1'b1;

      for (int i = 0; i < 8; i++) begin
         wait_req();
         chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
         for (int j = 0; j < i % 3; j++) begin
            mem_ready = 1'b0;
            step();
         end
         chk($sformatf("v%0d_req_hold", i), {31'd0, mem_req}, 32'd1);
         mem_ready = 1'b1;
         mem_rdata = vecs[i].rdata;
         step();
         mem_rdata = 32'hDEAD_BEEF;
         chk($sformatf("v%0d_valid", i), {31'd0, insn_valid}, 32'd1);
         chk($sformatf("v%0d_insn", i),  insn, vecs[i].rdata);
         chk($sformatf("v%0d_pc", i),    pc,   vecs[i].addr);
         chk($sformatf("v%0d_req_off", i), {31'd0, mem_req}, 32'd0);
         step();
         mem_ready = 1'b0;
         chk($sformatf("v%0d_insn_held", i), insn, vecs[i].rdata);
         exec_done   = 1'b1;
         pc_next_sel = vecs[i].sel;
         pc_target   = vecs[i].tgt;
         step();
         exec_done = 1'b0;
         chk($sformatf("v%0d_pc_after", i), pc, vecs[i].exp_next);
         if (vecs[i].exp_fault) begin
            chk($sformatf("v%0d_fault", i), {31'd0, fault}, 32'd1);
            chk($sformatf("v%0d_fcode", i), {30'd0, fault_code}, 32'd1);
            chk($sformatf("v%0d_flt_req", i), {31'd0, mem_req}, 32'd0);
            step();
            chk($sformatf("v%0d_flt_sticky", i), {31'd0, fault}, 32'd1);
            pulse_reset();
         end else begin
            chk($sformatf("v%0d_next_req", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("v%0d_next_addr", i), mem_addr, vecs[i].exp_next);
            chk($sformatf("v%0d_valid_off", i), {31'd0, insn_valid}, 32'd0);
         end
      end

      // Timeout: 16 FETCH cycles without ready.
      pulse_reset();
      wait_req();
      for (int k = 0; k < 15; k++) step();
      chk("to_still_fetch", {31'd0, mem_req}, 32'd1);
      chk("to_no_fault_yet", {31'd0, fault}, 32'd0);
      step();
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_fcode", {30'd0, fault_code}, 32'd2);
      chk("to_req_off", {31'd0, mem_req}, 32'd0);
      mem_ready = 1'b1; exec_done = 1'b1;
      step(); step();
      mem_ready = 1'b0; exec_done = 1'b0;
      chk("to_sticky", {30'd0, fault_code}, 32'd2);
      chk("to_valid_off", {31'd0, insn_valid}, 32'd0);

      // Ready on the 16th FETCH cycle wins over timeout.
      pulse_reset();
      wait_req();
      for (int k = 0; k < 15; k++) step();
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      step();
      mem_ready = 1'b0;
      chk("pri_valid", {31'd0, insn_valid}, 32'd1);
      chk("pri_no_fault", {31'd0, fault}, 32'd0);
      chk("pri_insn", insn, 32'h1234_5678);

      // Advance to pc=4 in ISSUE, then async reset mid-cycle.
      exec_done = 1'b1; pc_next_sel = 1'b0;
      step();
      exec_done = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      step();
      mem_ready = 1'b0;
      chk("ar_pre_pc", pc, 32'h0000_0004);
      chk("ar_pre_valid", {31'd0, insn_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("ar");
      @(negedge clk);
      rst_n = 1'b1;
      wait_req();
      chk("ar_addr", mem_addr, 32'h0000_0000);

      // run=0 at exec_done parks in IDLE; restart fetches the updated pc.
      mem_ready = 1'b1; mem_rdata = 32'h0000_0093;
      step();
      mem_ready = 1'b0;
      run = 1'b0;
      exec_done = 1'b1; pc_next_sel = 1'b0;
      step();
      exec_done = 1'b0;
      chk("idle_req_off", {31'd0, mem_req}, 32'd0);
      chk("idle_pc", pc, 32'h0000_0004);
      step(); step();
      chk("idle_stays", {31'd0, mem_req}, 32'd0);
      run = 1'b1;
      step();
      chk("restart_req", {31'd0, mem_req}, 32'd1);
      chk("restart_addr", mem_addr, 32'h0000_0004);
      run = 1'b0;
      step(); step();
      chk("run_drop_no_abort", {31'd0, mem_req}, 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h0000_0113;
      step();
      mem_ready = 1'b0;
      chk("run_drop_valid", {31'd0, insn_valid}, 32'd1);
      chk("run_drop_insn", insn, 32'h0000_0113);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
